dds_sweep_ctrl: RTL and testbench

Stepped-frequency sweep controller placed directly upstream of the DDS core. It drives the DDS phase increment, accumulator reset/enable and data-valid inputs, and consumes the DDS sine zero-crossing flag to dwell a programmed number of sine periods at each frequency step. Each step opens a measurement window by asserting data-valid, which lets the downstream system-identification chain acquire one frequency point per step.

---
 rtl/dds_sweep_ctrl.sv | 224 ++++++++++++++++++++++
 tb/tb_dds_sweep_ctrl.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dds_sweep_ctrl.sv
// dds_sweep_ctrl: stepped-frequency sweep controller sitting upstream of a DDS core.
//
// For each frequency step it settles for a programmed number of cycles, then opens a
// measurement window (oc_val_data) that stays open for 2*max(n_periods,1) sine
// zero crossings reported by the DDS. The phase increment advances by f_step
// (modulo 2^M) between steps. The accumulator is only reset in IDLE/LOAD, so phase
// is continuous across steps.
//
// Ports:
//   clk, ic_rst        clock (rising edge), asynchronous active-high reset
//   ic_start           start pulse, sampled only in IDLE
//   ic_abort           abort, returns to IDLE on the next edge
//   id_f_start         phase increment of step 0
//   id_f_step          phase increment added per step (wraps modulo 2^M)
//   id_n_steps         number of steps (0 -> straight to DONE)
//   id_n_periods       sine periods measured per step (0 treated as 1)
//   id_settle          cycles discarded after each frequency change
//   ic_zero_crossing   one-cycle zero-crossing flag from the DDS
//   od_p_ac            phase increment to the DDS
//   oc_rst_ac          DDS accumulator reset
//   oc_en_ac           DDS accumulator enable
//   oc_val_data        measurement window
//   od_step_idx        current step index
//   oc_step_done       one-cycle pulse at the end of each step
//   oc_busy            sweep in progress
//   oc_done            one-cycle pulse on normal sweep completion
module dds_sweep_ctrl #(
  parameter int unsigned M        = 32,
  parameter int unsigned NSTEP_W  = 16,
  parameter int unsigned NPER_W   = 12,
  parameter int unsigned SETTLE_W = 8
) (
  input  logic                clk,
  input  logic                ic_rst,
  input  logic                ic_start,
  input  logic                ic_abort,
  input  logic [M-1:0]        id_f_start,
  input  logic [M-1:0]        id_f_step,
  input  logic [NSTEP_W-1:0]  id_n_steps,
  input  logic [NPER_W-1:0]   id_n_periods,
  input  logic [SETTLE_W-1:0] id_settle,
  input  logic                ic_zero_crossing,
  output logic [M-1:0]        od_p_ac,
  output logic                oc_rst_ac,
  output logic                oc_en_ac,
  output logic                oc_val_data,
  output logic [NSTEP_W-1:0]  od_step_idx,
  output logic                oc_step_done,
  output logic                oc_busy,
  output logic                oc_done
);

  localparam int unsigned CntW = NPER_W + 1;

  localparam logic [2:0] StIdle    = 3'd0;
  localparam logic [2:0] StLoad    = 3'd1;
  localparam logic [2:0] StSettle  = 3'd2;
  localparam logic [2:0] StMeasure = 3'd3;
  localparam logic [2:0] StNext    = 3'd4;
  localparam logic [2:0] StDone    = 3'd5;

  // Reset synchroniser: assertion is asynchronous, release waits two clock edges.
  logic rst_meta_q;
  logic rst_sync_q;

  always_ff @(posedge clk or posedge ic_rst) begin
    if (ic_rst) begin
      rst_meta_q <= 1'b1;
      rst_sync_q <= 1'b1;
    end else begin
      rst_meta_q <= 1'b0;
      rst_sync_q <= rst_meta_q;
    end
  end

  logic [2:0]          state_q, state_d;
  logic [M-1:0]        p_q, p_d;
  logic [NSTEP_W-1:0]  idx_q, idx_d;
  logic [M-1:0]        f_step_q, f_step_d;
  logic [NSTEP_W-1:0]  n_steps_q, n_steps_d;
  logic [NPER_W-1:0]   n_per_q, n_per_d;
  logic [SETTLE_W-1:0] settle_q, settle_d;
  logic [SETTLE_W-1:0] settle_cnt_q, settle_cnt_d;
  logic [CntW-1:0]     zc_cnt_q, zc_cnt_d;

  logic [NPER_W-1:0]   n_per_eff;
  logic [CntW-1:0]     zc_target;
  logic                last_step;
  logic                begin_step;

  // A zero period count behaves as one period, i.e. two crossings.
  assign n_per_eff = (n_per_q == '0) ? NPER_W'(1) : n_per_q;
  assign zc_target = {n_per_eff, 1'b0};
  assign last_step = (idx_q == (n_steps_q - NSTEP_W'(1)));

  always_comb begin
    state_d      = state_q;
    p_d          = p_q;
    idx_d        = idx_q;
    f_step_d     = f_step_q;
    n_steps_d    = n_steps_q;
    n_per_d      = n_per_q;
    settle_d     = settle_q;
    settle_cnt_d = settle_cnt_q;
    zc_cnt_d     = zc_cnt_q;
    begin_step   = 1'b0;

    case (state_q)
      StIdle: begin
        if (ic_start) begin
          f_step_d  = id_f_step;
          n_steps_d = id_n_steps;
          n_per_d   = id_n_periods;
          settle_d  = id_settle;
          p_d       = id_f_start;
          idx_d     = '0;
          state_d   = StLoad;
        end
      end

      StLoad: begin
        if (n_steps_q == '0) begin
          state_d = StDone;
        end else begin
          begin_step = 1'b1;
        end
      end

      StSettle: begin
        if (settle_cnt_q == '0) begin
          state_d  = StMeasure;
          zc_cnt_d = '0;
        end else begin
          settle_cnt_d = settle_cnt_q - SETTLE_W'(1);
        end
      end

      StMeasure: begin
        // Saturating count; the crossing that reaches the target ends the window.
        if (ic_zero_crossing && (zc_cnt_q != zc_target)) begin
          zc_cnt_d = zc_cnt_q + CntW'(1);
          if (zc_cnt_q == (zc_target - CntW'(1))) begin
            state_d = StNext;
          end
        end
      end

      StNext: begin
        if (last_step) begin
          state_d = StDone;
        end else begin
          p_d        = p_q + f_step_q;
          idx_d      = idx_q + NSTEP_W'(1);
          begin_step = 1'b1;
        end
      end

      StDone: begin
        state_d = StIdle;
        p_d     = '0;
        idx_d   = '0;
      end

      default: begin
        state_d = StIdle;
        p_d     = '0;
        idx_d   = '0;
      end
    endcase

    // Common entry into a frequency step from LOAD or NEXT.
    if (begin_step) begin
      if (settle_q == '0) begin
        state_d  = StMeasure;
        zc_cnt_d = '0;
      end else begin
        state_d      = StSettle;
        settle_cnt_d = settle_q - SETTLE_W'(1);
      end
    end

    // Abort beats every other transition, including a same-edge crossing.
    if (ic_abort && (state_q != StIdle)) begin
      state_d = StIdle;
      p_d     = '0;
      idx_d   = '0;
    end
  end

  always_ff @(posedge clk or posedge rst_sync_q) begin
    if (rst_sync_q) begin
      state_q      <= StIdle;
      p_q          <= '0;
      idx_q        <= '0;
      f_step_q     <= '0;
      n_steps_q    <= '0;
      n_per_q      <= '0;
      settle_q     <= '0;
      settle_cnt_q <= '0;
      zc_cnt_q     <= '0;
    end else begin
      state_q      <= state_d;
      p_q          <= p_d;
      idx_q        <= idx_d;
      f_step_q     <= f_step_d;
      n_steps_q    <= n_steps_d;
      n_per_q      <= n_per_d;
      settle_q     <= settle_d;
      settle_cnt_q <= settle_cnt_d;
      zc_cnt_q     <= zc_cnt_d;
    end
  end

  // Outputs are decoded from registered state only.
  assign od_p_ac      = p_q;
  assign od_step_idx  = idx_q;
  assign oc_rst_ac    = (state_q == StIdle) || (state_q == StLoad);
  assign oc_en_ac     = (state_q == StSettle) || (state_q == StMeasure) || (state_q == StNext);
  assign oc_val_data  = (state_q == StMeasure);
  assign oc_step_done = (state_q == StNext);
  assign oc_done      = (state_q == StDone);
  assign oc_busy      = (state_q != StIdle);

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Self-checking bench for dds_sweep_ctrl. Zero crossings are random pulses; the
// expected sweep (per-step phase increment, settle length, crossings per window,
// step/done pulses) is walked procedurally from the sweep parameters.
module tb_dds_sweep_ctrl;

  localparam int unsigned M        = 32;
  localparam int unsigned NSTEP_W  = 16;
  localparam int unsigned NPER_W   = 12;
  localparam int unsigned SETTLE_W = 8;

  logic                clk = 1'b0;
  logic                ic_rst = 1'b1;
  logic                ic_start = 1'b0;
  logic                ic_abort = 1'b0;
  logic [M-1:0]        id_f_start = '0;
  logic [M-1:0]        id_f_step = '0;
  logic [NSTEP_W-1:0]  id_n_steps = '0;
  logic [NPER_W-1:0]   id_n_periods = '0;
  logic [SETTLE_W-1:0] id_settle = '0;
  logic                ic_zero_crossing = 1'b0;
  logic [M-1:0]        od_p_ac;
  logic                oc_rst_ac;
  logic                oc_en_ac;
  logic                oc_val_data;
  logic [NSTEP_W-1:0]  od_step_idx;
  logic                oc_step_done;
  logic                oc_busy;
  logic                oc_done;

  int n_tests = 0;
  int n_fail  = 0;

  dds_sweep_ctrl #(
    .M        (M),
    .NSTEP_W  (NSTEP_W),
    .NPER_W   (NPER_W),
    .SETTLE_W (SETTLE_W)
  ) dut (
    .clk              (clk),
    .ic_rst           (ic_rst),
    .ic_start         (ic_start),
    .ic_abort         (ic_abort),
    .id_f_start       (id_f_start),
    .id_f_step        (id_f_step),
    .id_n_steps       (id_n_steps),
    .id_n_periods     (id_n_periods),
    .id_settle        (id_settle),
    .ic_zero_crossing (ic_zero_crossing),
    .od_p_ac          (od_p_ac),
    .oc_rst_ac        (oc_rst_ac),
    .oc_en_ac         (oc_en_ac),
    .oc_val_data      (oc_val_data),
    .od_step_idx      (od_step_idx),
    .oc_step_done     (oc_step_done),
    .oc_busy          (oc_busy),
    .oc_done          (oc_done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_rst_ac"}, oc_rst_ac, 1);
    chk({tag, "_en"}, oc_en_ac, 0);
    chk({tag, "_val"}, oc_val_data, 0);
    chk({tag, "_busy"}, oc_busy, 0);
    chk({tag, "_done"}, oc_done, 0);
    chk({tag, "_step_done"}, oc_step_done, 0);
    chk({tag, "_p"}, od_p_ac, 0);
    chk({tag, "_idx"}, od_step_idx, 0);
  endtask

  // Random crossings and stray start pulses while the sweep is running.
  task automatic rand_in();
    ic_zero_crossing = 1'($urandom_range(0, 1));
    ic_start         = 1'($urandom_range(0, 1));
  endtask

  // Runs one sweep from IDLE; abort_step >= 0 aborts in the MEASURE window of that step.
  task automatic run_sweep(input logic [31:0] fs, input logic [31:0] fst, input int ns,
                           input int np, input int st, input int abort_step);
    logic [31:0] exp_p;
    int          cnt;
    int          budget;
    int          need;
    logic        zc;
    id_f_start   = fs;
    id_f_step    = fst;
    id_n_steps   = NSTEP_W'(ns);
    id_n_periods = NPER_W'(np);
    id_settle    = SETTLE_W'(st);
    ic_start     = 1'b1;
    tick();
    ic_start = 1'b0;
    // Parameters must have been latched; scramble the live inputs.
    id_f_start   = $urandom;
    id_f_step    = $urandom;
    id_n_steps   = NSTEP_W'($urandom);
    id_n_periods = NPER_W'($urandom);
    id_settle    = SETTLE_W'($urandom);
    chk("load_busy", oc_busy, 1);
    chk("load_rst_ac", oc_rst_ac, 1);
    chk("load_en", oc_en_ac, 0);
    chk("load_val", oc_val_data, 0);
    chk("load_p", od_p_ac, fs);
    chk("load_idx", od_step_idx, 0);
    if (ns == 0) begin
      ic_zero_crossing = 1'b1;
      tick();
      ic_zero_crossing = 1'b0;
      chk("zero_done", oc_done, 1);
      chk("zero_en", oc_en_ac, 0);
      chk("zero_busy", oc_busy, 1);
      chk("zero_rst_ac", oc_rst_ac, 0);
      tick();
      chk_idle("zero_after");
      return;
    end
    need  = 2 * ((np == 0) ? 1 : np);
    exp_p = fs;
    for (int k = 0; k < ns; k++) begin
      for (int s = 0; s < st; s++) begin
        rand_in();
        tick();
        chk("settle_en", oc_en_ac, 1);
        chk("settle_val", oc_val_data, 0);
        chk("settle_rst_ac", oc_rst_ac, 0);
        chk("settle_p", od_p_ac, exp_p);
        chk("settle_idx", od_step_idx, NSTEP_W'(k));
      end
      // Crossing here lands on the edge into MEASURE and must not count.
      rand_in();
      tick();
      cnt    = 0;
      budget = 0;
      while (cnt < need && budget < 2000) begin
        chk("meas_val", oc_val_data, 1);
        chk("meas_en", oc_en_ac, 1);
        chk("meas_step_done", oc_step_done, 0);
        chk("meas_p", od_p_ac, exp_p);
        chk("meas_idx", od_step_idx, NSTEP_W'(k));
        if (k == abort_step && budget == 2) begin
          ic_abort         = 1'b1;
          ic_zero_crossing = 1'b1;
          ic_start         = 1'b0;
          tick();
          ic_abort         = 1'b0;
          ic_zero_crossing = 1'b0;
          chk_idle("abort");
          tick();
          chk_idle("abort_after");
          return;
        end
        zc               = ($urandom_range(0, 2) == 0);
        ic_zero_crossing = zc;
        ic_start         = 1'($urandom_range(0, 1));
        if (zc) cnt++;
        budget++;
        tick();
      end
      chk("meas_budget", (budget < 2000), 1);
      chk("next_step_done", oc_step_done, 1);
      chk("next_en", oc_en_ac, 1);
      chk("next_val", oc_val_data, 0);
      chk("next_done", oc_done, 0);
      chk("next_p", od_p_ac, exp_p);
      chk("next_idx", od_step_idx, NSTEP_W'(k));
      exp_p = exp_p + fst;
    end
    ic_start         = 1'b0;
    ic_zero_crossing = 1'($urandom_range(0, 1));
    tick();
    ic_zero_crossing = 1'b0;
    chk("done_pulse", oc_done, 1);
    chk("done_step_done", oc_step_done, 0);
    chk("done_en", oc_en_ac, 0);
    chk("done_val", oc_val_data, 0);
    chk("done_rst_ac", oc_rst_ac, 0);
    chk("done_busy", oc_busy, 1);
    tick();
    chk_idle("after_done");
  endtask

  initial begin
    // Reset held for 3 cycles, then released.
    repeat (3) tick();
    chk_idle("rst_hold");
    ic_rst = 1'b0;
    repeat (3) tick();
    chk_idle("rst_release");

    // Basic sweep.
    run_sweep(32'h0100_0000, 32'h0080_0000, 3, 2, 8, -1);
    // Phase-increment wrap-around: second step is 0x00000100.
    run_sweep(32'hFFFF_FF00, 32'h0000_0200, 2, 1, 3, -1);
    // Edge parameters.
    run_sweep(32'h0000_1000, 32'h0000_0010, 0, 2, 4, -1);
    run_sweep(32'h0000_2000, 32'h0000_0020, 2, 0, 2, -1);
    run_sweep(32'h0000_3000, 32'h0000_0030, 3, 1, 0, -1);
    // Abort in MEASURE of step 1, then a full sweep.
    run_sweep(32'h0200_0000, 32'h0010_0000, 3, 3, 2, 1);
    run_sweep(32'h0200_0000, 32'h0010_0000, 3, 2, 2, -1);
    // Randomised sweeps.
    for (int r = 0; r < 4; r++) begin
      run_sweep($urandom, $urandom, int'($urandom_range(1, 4)), int'($urandom_range(0, 3)),
                int'($urandom_range(0, 5)), -1);
    end

    // Asynchronous reset between edges in the middle of SETTLE.
    id_f_start   = 32'h0000_1234;
    id_f_step    = 32'h0000_0001;
    id_n_steps   = 16'd2;
    id_n_periods = 12'd1;
    id_settle    = 8'd20;
    ic_start     = 1'b1;
    tick();
    ic_start = 1'b0;
    tick();
    tick();
    chk("ar_in_settle", oc_en_ac, 1);
    #3;
    ic_rst = 1'b1;
    #1;
    chk_idle("async_rst");
    tick();
    tick();
    ic_rst = 1'b0;
    repeat (4) tick();
    chk_idle("post_async_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
